pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the 16-bit program counter and sequences instruction fetch for the RISC core. Each cycle it selects the next PC: sequential (PC+INC), branch target or jump target. It also holds the PC under stall or halt. It drives a req/ack handshake toward instruction memory and counts accepted fetches.

Parameters:
RESET_VEC, 16'h0000, PC value loaded on reset
TRAP_VEC, 16'h0010, PC loaded on misaligned redirect (optional feature only)
INC, 2, sequential PC increment in bytes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pc_out  out  16  current fetch address (registered)
fetch_req  out  1  fetch request to instruction memory (registered)
fetch_ack  in  1  memory accepts the fetch at pc_out this cycle
stall  in  1  pipeline stall; suspends fetch
br_taken  in  1  branch resolved taken (single-cycle pulse)
br_target  in  16  branch target address
jmp_en  in  1  unconditional jump (single-cycle pulse)
jmp_target  in  16  jump target address
halt  in  1  enter HALTED
resume  in  1  leave HALTED
fetch_count  out  16  number of accepted fetches, wraps
misalign_err  out  1  one-cycle pulse on misaligned redirect (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst high at an edge): pc_out=RESET_VEC, fetch_req=0, fetch_count=0, misalign_err=0, state=BOOT. rst has priority over all inputs, including mid-handshake. Any outstanding request is dropped.
- State machine:
  - BOOT -> REQ on the first edge with rst low.
  - REQ: fetch_req=1.
    - halt=1 -> HALTED.
    - else stall=1 -> HOLD.
    - else stay in REQ.
  - HOLD: fetch_req=0. halt=1 -> HALTED. stall=0 -> REQ.
  - HALTED: fetch_req=0. Leaves to REQ only on resume=1 with halt=0. With halt=1 and resume=1 together, it stays HALTED.
- Next-PC priority, evaluated every edge in REQ, HOLD and HALTED:
  1. jmp_en -> jmp_target.
  2. br_taken -> br_target.
  3. fetch_req & fetch_ack -> pc_out+INC.
  4. Otherwise hold pc_out.
- jmp_en and br_taken in the same cycle: the jump wins and the branch is discarded.
- A redirect in a cycle with fetch_ack: the accepted fetch is counted, but pc_out takes the redirect target, not PC+INC.
- A redirect while in REQ without ack: the pending request is abandoned and pc_out changes to the target. fetch_req stays high.
- pc_out changes only on ack or redirect. Memory must sample the address when ack is high.
- Redirects in HOLD or HALTED update pc_out. They are never lost.
- Stall and ack in the same cycle: the fetch is accepted (PC advances, count increments) and the state moves to HOLD.
- fetch_req deasserts on the edge that leaves REQ. Latency from stall=1 to fetch_req=0 is 1 cycle.
- Arithmetic: unsigned 16-bit modulo. 16'hFFFE+2 = 16'h0000 with no flag. fetch_count wraps from 16'hFFFF to 0.
- BOOT performs no fetch. The first request to RESET_VEC appears in the cycle after rst deasserts.

Optional Feature:
Macro: PC_ALIGN_CHECK_EN
- Defined: a winning redirect target with bit0=1 loads TRAP_VEC into pc_out. misalign_err pulses high for exactly the following cycle.
- Not defined: bit0 of any redirect target is forced to 0, and misalign_err is tied to 0.

Test Plan:
- Reset release, fetch_ack held high -> pc_out sequence 0000, 0002, 0004, 0006; fetch_count=3 after three acks; fetch_req rises 1 cycle after rst falls.
- pc_out=FFFE, ack -> pc_out=0000, no other side effect.
- jmp_en (target 0100) and br_taken (target 0200) in the same cycle as ack -> pc_out=0100; fetch_count increments by 1.
- stall high for 3 cycles with br_taken (target 0040) in the 2nd stall cycle -> fetch_req=0 one cycle after stall rises; pc_out=0040 on stall release; next request is to 0040.
- halt, then resume asserted together with halt, then resume alone -> stays HALTED, then REQ; pc_out unchanged throughout.
- With PC_ALIGN_CHECK_EN: jmp_target=0103 -> pc_out=0010, misalign_err pulses 1 cycle. Without the macro -> pc_out=0102, misalign_err=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: next-PC selection, req/ack fetch handshake, accepted-fetch counter.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] TRAP_VEC  = 16'h0010,
  parameter int unsigned INC       = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc_out,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        jmp_en,
  input  logic [15:0] jmp_target,
  input  logic        halt,
  input  logic        resume,
  output logic [15:0] fetch_count,
  output logic        misalign_err
);

  localparam logic [15:0] INC_W = 16'(INC);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        err_q, err_d;

  logic        redir;
  logic [15:0] redir_tgt;
  logic        accept;

  assign redir     = jmp_en | br_taken;
  assign redir_tgt = jmp_en ? jmp_target : br_target;
  assign accept    = req_q & fetch_ack;

`ifndef PC_ALIGN_CHECK_EN
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      S_BOOT:   state_d = S_REQ;
      S_REQ: begin
        if (halt)       state_d = S_HALTED;
        else if (stall) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (halt)        state_d = S_HALTED;
        else if (!stall) state_d = S_REQ;
      end
      S_HALTED: begin
        if (resume && !halt) state_d = S_REQ;
      end
      default:  state_d = S_BOOT;
    endcase

    // BOOT performs no fetch and ignores redirects; every other state evaluates next-PC.
    if (state_q != S_BOOT) begin
      if (accept) cnt_d = cnt_q + 16'd1;
      if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
        if (redir_tgt[0]) begin
          pc_d  = TRAP_VEC;
          err_d = 1'b1;
        end else begin
          pc_d = redir_tgt;
        end
`else
        pc_d = {redir_tgt[15:1], 1'b0};
`endif
      end else if (accept) begin
        pc_d = pc_q + INC_W;
      end
    end

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      cnt_q   <= 16'd0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign pc_out       = pc_q;
  assign fetch_req    = req_q;
  assign fetch_count  = cnt_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a behavioural fetch model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_out;
  logic        fetch_req;
  logic        fetch_ack;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp_en;
  logic [15:0] jmp_target;
  logic        halt;
  logic        resume;
  logic [15:0] fetch_count;
  logic        misalign_err;

  int tests_run = 0;
  int failed    = 0;

  // Model: the core is either booting, fetching, stalled or halted.
  bit          m_boot;
  bit          m_halted;
  bit          m_fetching;
  logic [15:0] m_pc;
  logic [15:0] m_cnt;
  bit          m_err;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .fetch_req    (fetch_req),
    .fetch_ack    (fetch_ack),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_en       (jmp_en),
    .jmp_target   (jmp_target),
    .halt         (halt),
    .resume       (resume),
    .fetch_count  (fetch_count),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int unsigned target;
    bit          took;
    if (rst) begin
      m_boot = 1; m_halted = 0; m_fetching = 0;
      m_pc = 16'h0000; m_cnt = 16'h0000; m_err = 0;
      return;
    end
    m_err = 0;
    if (m_boot) begin
      m_boot = 0;
      m_fetching = 1;
      return;
    end
    took = m_fetching && fetch_ack;
    if (took) m_cnt = 16'((int'(m_cnt) + 1) % 65536);
    if (jmp_en || br_taken) begin
      target = jmp_en ? jmp_target : br_target;
`ifdef PC_ALIGN_CHECK_EN
      if (target % 2 == 1) begin
        m_pc  = 16'h0010;
        m_err = 1;
      end else begin
        m_pc = 16'(target);
      end
`else
      m_pc = 16'(target - (target % 2));
`endif
    end else if (took) begin
      m_pc = 16'((int'(m_pc) + 2) % 65536);
    end
    if (m_halted) begin
      if (resume && !halt) begin m_halted = 0; m_fetching = 1; end
    end else if (halt) begin
      m_halted = 1; m_fetching = 0;
    end else begin
      m_fetching = !stall;
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".pc"},  pc_out,              m_pc);
    check({tag, ".req"}, {15'd0, fetch_req},  {15'd0, m_fetching});
    check({tag, ".cnt"}, fetch_count,         m_cnt);
    check({tag, ".err"}, {15'd0, misalign_err}, {15'd0, m_err});
  endtask

  task automatic idle_inputs();
    fetch_ack = 0; stall = 0; br_taken = 0; br_target = 16'h0;
    jmp_en = 0; jmp_target = 16'h0; halt = 0; resume = 0;
  endtask

  initial begin
    logic [15:0] pc_saved;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    check("reset.pc",  pc_out, 16'h0000);
    check("reset.req", {15'd0, fetch_req}, 16'h0000);
    check("reset.cnt", fetch_count, 16'h0000);

    rst = 0; fetch_ack = 1;
    cycle("boot");
    check("boot.req_rise", {15'd0, fetch_req}, 16'h0001);
    check("boot.pc", pc_out, 16'h0000);
    cycle("seq1"); check("seq1.pc", pc_out, 16'h0002);
    cycle("seq2"); check("seq2.pc", pc_out, 16'h0004);
    cycle("seq3"); check("seq3.pc", pc_out, 16'h0006);
    check("seq3.cnt", fetch_count, 16'd3);

    fetch_ack = 0; jmp_en = 1; jmp_target = 16'hFFFE;
    cycle("to_fffe"); jmp_en = 0;
    check("to_fffe.pc", pc_out, 16'hFFFE);
    fetch_ack = 1;
    cycle("wrap"); check("wrap.pc", pc_out, 16'h0000);
    check("wrap.cnt", fetch_count, 16'd4);
    check("wrap.err", {15'd0, misalign_err}, 16'h0000);

    jmp_en = 1; jmp_target = 16'h0100; br_taken = 1; br_target = 16'h0200;
    cycle("jmp_br"); idle_inputs();
    check("jmp_br.pc", pc_out, 16'h0100);
    check("jmp_br.cnt", fetch_count, 16'd5);

    stall = 1;
    cycle("stall1"); check("stall1.req", {15'd0, fetch_req}, 16'h0000);
    br_taken = 1; br_target = 16'h0040;
    cycle("stall2"); br_taken = 0;
    cycle("stall3");
    stall = 0;
    cycle("unstall");
    check("unstall.pc", pc_out, 16'h0040);
    check("unstall.req", {15'd0, fetch_req}, 16'h0001);
    fetch_ack = 1;
    cycle("after_stall"); fetch_ack = 0;
    check("after_stall.pc", pc_out, 16'h0042);

    pc_saved = pc_out;
    halt = 1;
    cycle("halt"); check("halt.req", {15'd0, fetch_req}, 16'h0000);
    resume = 1;
    cycle("halt_resume"); check("halt_resume.req", {15'd0, fetch_req}, 16'h0000);
    halt = 0;
    cycle("resume"); resume = 0;
    check("resume.req", {15'd0, fetch_req}, 16'h0001);
    check("resume.pc", pc_out, pc_saved);

    jmp_en = 1; jmp_target = 16'h0103;
    cycle("misalign"); jmp_en = 0;
`ifdef PC_ALIGN_CHECK_EN
    check("misalign.pc", pc_out, 16'h0010);
    check("misalign.err", {15'd0, misalign_err}, 16'h0001);
`else
    check("misalign.pc", pc_out, 16'h0102);
    check("misalign.err", {15'd0, misalign_err}, 16'h0000);
`endif
    cycle("misalign_after");
    check("misalign_after.err", {15'd0, misalign_err}, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      fetch_ack  = $urandom_range(0, 1) == 1;
      stall      = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      br_target  = 16'($urandom);
      jmp_en     = ($urandom_range(0, 9) == 0);
      jmp_target = 16'($urandom);
      halt       = ($urandom_range(0, 15) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        jmp_en = 1; jmp_target = 16'hFFFE;
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
